// File: rtl/fp_regfile_pkg.sv
// Shared defaults and types for the floating-point register file and its scoreboard.
package fp_regfile_pkg;

    localparam int FP_DATA_W   = 32;
    localparam int FP_NUM_REGS = 32;
    localparam int FP_AW       = $clog2(FP_NUM_REGS);

    // Register address and data types for the default configuration.
    typedef logic [FP_AW-1:0]     reg_addr_t;
    typedef logic [FP_DATA_W-1:0] reg_data_t;

endpackage : fp_regfile_pkg

// File: rtl/fp_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an outstanding result, gates issue,
// and keeps a registered count of reserved registers.
module fp_scoreboard
    import fp_regfile_pkg::*;
#(
    parameter  int NUM_REGS = FP_NUM_REGS,
    parameter  int NUM_RD   = 3,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_RD-1:0][AW-1:0]  raddr_i,
    output logic [NUM_RD-1:0]          rbusy_o,
    input  logic                       issue_valid_i,
    input  logic [AW-1:0]              issue_rd_i,
    output logic                       issue_ready_o,
    input  logic                       wb_valid_i,
    input  logic [AW-1:0]              wb_addr_i,
    input  logic                       ld_valid_i,
    input  logic [AW-1:0]              ld_addr_i,
    input  logic                       flush_i,
    output logic [AW:0]                pending_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [AW:0]         pending_q, pending_d;
    logic [NUM_REGS-1:0] wr_hit;
    logic                issue_fire;

    // One-hot map of registers receiving a result this cycle (wb and/or ld).
    always_comb begin
        wr_hit = '0;
        if (wb_valid_i) wr_hit[wb_addr_i] = 1'b1;
        if (ld_valid_i) wr_hit[ld_addr_i] = 1'b1;
    end

    // A busy register may be re-reserved in the cycle its result arrives; flush and reset block issue.
    assign issue_ready_o = rst_ni && !flush_i && (!busy_q[issue_rd_i] || wr_hit[issue_rd_i]);
    assign issue_fire    = issue_valid_i && issue_ready_o;

    // Per-port busy view: a result arriving this cycle hides the pending reservation.
    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            rbusy_o[k] = busy_q[raddr_i[k]] && !wr_hit[raddr_i[k]];
        end
    end

    // Next busy state: clear on write, clear all on flush, then set on issue so set wins.
    always_comb begin
        busy_d    = busy_q & ~wr_hit;
        if (flush_i)    busy_d = '0;
        if (issue_fire) busy_d[issue_rd_i] = 1'b1;
        pending_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            pending_d = pending_d + (AW+1)'(busy_d[i]);
        end
    end

    // Busy bits and their population count advance together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q    <= '0;
            pending_q <= '0;
        end else begin
            busy_q    <= busy_d;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule : fp_scoreboard

// File: rtl/fp_regfile_sb.sv
// Floating-point register file with write-through read bypass and a busy-bit scoreboard.
// Two write ports (FPU writeback and load); writeback wins on an address collision.
module fp_regfile_sb
    import fp_regfile_pkg::*;
#(
    parameter  int DATA_W   = FP_DATA_W,
    parameter  int NUM_REGS = FP_NUM_REGS,
    parameter  int NUM_RD   = 3,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_RD-1:0][AW-1:0]     raddr_i,
    output logic [NUM_RD-1:0][DATA_W-1:0] rdata_o,
    output logic [NUM_RD-1:0]             rbusy_o,
    input  logic                          issue_valid_i,
    input  logic [AW-1:0]                 issue_rd_i,
    output logic                          issue_ready_o,
    input  logic                          wb_valid_i,
    input  logic [AW-1:0]                 wb_addr_i,
    input  logic [DATA_W-1:0]             wb_data_i,
    input  logic                          ld_valid_i,
    input  logic [AW-1:0]                 ld_addr_i,
    input  logic [DATA_W-1:0]             ld_data_i,
    input  logic                          flush_i,
    output logic [AW:0]                   pending_o
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;

    // Next array contents: load first, writeback second so writeback wins a collision.
    always_comb begin
        // NOTE: blocking assignments in combinational logic execute in order, so the later wb write overrides ld.
        regs_d = regs_q;
        if (ld_valid_i) regs_d[ld_addr_i] = ld_data_i;
        if (wb_valid_i) regs_d[wb_addr_i] = wb_data_i;
    end

    // Register array; writes land at the clock edge, also during a flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the array is reset explicitly because it must read zero right after reset; this rules out RAM macros.
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports with write-through bypass, same wb-over-ld priority as the array.
    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            rdata_o[k] = regs_q[raddr_i[k]];
            if (ld_valid_i && (ld_addr_i == raddr_i[k])) rdata_o[k] = ld_data_i;
            if (wb_valid_i && (wb_addr_i == raddr_i[k])) rdata_o[k] = wb_data_i;
        end
    end

    fp_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD)
    ) u_scoreboard (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .raddr_i       (raddr_i),
        .rbusy_o       (rbusy_o),
        .issue_valid_i (issue_valid_i),
        .issue_rd_i    (issue_rd_i),
        .issue_ready_o (issue_ready_o),
        .wb_valid_i    (wb_valid_i),
        .wb_addr_i     (wb_addr_i),
        .ld_valid_i    (ld_valid_i),
        .ld_addr_i     (ld_addr_i),
        .flush_i       (flush_i),
        .pending_o     (pending_o)
    );

endmodule : fp_regfile_sb

// File: tb/tb_fp_regfile_sb.sv
// Directed, table-driven bench for fp_regfile_sb (default parameters).
module tb_fp_regfile_sb;
    import fp_regfile_pkg::*;

    localparam int NRD = 3;

    logic                       clk;
    logic                       rst_n;
    logic [NRD-1:0][FP_AW-1:0]  raddr;
    logic [NRD-1:0][31:0]       rdata;
    logic [NRD-1:0]             rbusy;
    logic                       issue_valid;
    reg_addr_t                  issue_rd;
    logic                       issue_ready;
    logic                       wb_valid;
    reg_addr_t                  wb_addr;
    reg_data_t                  wb_data;
    logic                       ld_valid;
    reg_addr_t                  ld_addr;
    reg_data_t                  ld_data;
    logic                       flush;
    logic [FP_AW:0]             pending;

    int checks   = 0;
    int failures = 0;

    fp_regfile_sb dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .raddr_i       (raddr),
        .rdata_o       (rdata),
        .rbusy_o       (rbusy),
        .issue_valid_i (issue_valid),
        .issue_rd_i    (issue_rd),
        .issue_ready_o (issue_ready),
        .wb_valid_i    (wb_valid),
        .wb_addr_i     (wb_addr),
        .wb_data_i     (wb_data),
        .ld_valid_i    (ld_valid),
        .ld_addr_i     (ld_addr),
        .ld_data_i     (ld_data),
        .flush_i       (flush),
        .pending_o     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wb_v;  logic [4:0] wb_a;  logic [31:0] wb_d;
        logic        ld_v;  logic [4:0] ld_a;  logic [31:0] ld_d;
        logic        iss_v; logic [4:0] iss_a;
        logic [4:0]  ra;
        logic [31:0] e_rdata; logic e_rbusy; logic e_ready; logic [5:0] e_pend;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic wv, logic [4:0] wa, logic [31:0] wd,
                                logic lv, logic [4:0] la, logic [31:0] ld,
                                logic iv, logic [4:0] ia, logic [4:0] ra,
                                logic [31:0] er, logic eb, logic ey, logic [5:0] ep);
        vec_t v;
        v.wb_v = wv; v.wb_a = wa; v.wb_d = wd;
        v.ld_v = lv; v.ld_a = la; v.ld_d = ld;
        v.iss_v = iv; v.iss_a = ia; v.ra = ra;
        v.e_rdata = er; v.e_rbusy = eb; v.e_ready = ey; v.e_pend = ep;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        issue_valid = 1'b0; issue_rd = '0; flush = 1'b0;
    endtask

    initial begin
        //          wb_v wb_a  wb_d          ld_v ld_a  ld_d          iv  ia     ra     rdata         rb  rdy pend
        vecs[0]  = mk(1, 5'd3, 32'h40400000, 0, 5'd0, 32'h0,         0, 5'd0,  5'd3,  32'h40400000, 0, 1, 0);
        vecs[1]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,         0, 5'd0,  5'd3,  32'h40400000, 0, 1, 0);
        vecs[2]  = mk(1, 5'd5, 32'h3F800000, 1, 5'd5, 32'h40000000,  0, 5'd0,  5'd5,  32'h3F800000, 0, 1, 0);
        vecs[3]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,         0, 5'd0,  5'd5,  32'h3F800000, 0, 1, 0);
        vecs[4]  = mk(0, 5'd0, 32'h0,        1, 5'd10, 32'h12345678, 0, 5'd0,  5'd10, 32'h12345678, 0, 1, 0);
        vecs[5]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,         0, 5'd0,  5'd10, 32'h12345678, 0, 1, 0);
        vecs[6]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,         1, 5'd7,  5'd7,  32'h0,        0, 1, 0);
        vecs[7]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,         1, 5'd7,  5'd7,  32'h0,        1, 0, 1);
        vecs[8]  = mk(1, 5'd7, 32'h40E00000, 0, 5'd0, 32'h0,         0, 5'd7,  5'd7,  32'h40E00000, 0, 1, 1);
        vecs[9]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,         0, 5'd7,  5'd7,  32'h40E00000, 0, 1, 0);
        vecs[10] = mk(1, 5'd9, 32'h41100000, 0, 5'd0, 32'h0,         1, 5'd9,  5'd9,  32'h41100000, 0, 1, 0);
        vecs[11] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,         0, 5'd9,  5'd9,  32'h41100000, 1, 0, 1);
        vecs[12] = mk(0, 5'd0, 32'h0,        1, 5'd9, 32'hAAAA5555,  0, 5'd9,  5'd9,  32'hAAAA5555, 0, 1, 1);
        vecs[13] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,         0, 5'd9,  5'd9,  32'hAAAA5555, 0, 1, 0);
        vecs[14] = mk(1, 5'd0, 32'hDEADBEEF, 0, 5'd0, 32'h0,         0, 5'd0,  5'd0,  32'hDEADBEEF, 0, 1, 0);
        vecs[15] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,         0, 5'd0,  5'd0,  32'hDEADBEEF, 0, 1, 0);
        vecs[16] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,         1, 5'd11, 5'd11, 32'h0,        0, 1, 0);
        vecs[17] = mk(1, 5'd11, 32'h1,       0, 5'd0, 32'h0,         1, 5'd11, 5'd11, 32'h1,        0, 1, 1);
        vecs[18] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,         0, 5'd11, 5'd11, 32'h1,        1, 0, 1);
        vecs[19] = mk(1, 5'd11, 32'h2,       0, 5'd0, 32'h0,         0, 5'd11, 5'd11, 32'h2,        0, 1, 1);
        vecs[20] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,         0, 5'd11, 5'd11, 32'h2,        0, 1, 0);
        vecs[21] = mk(1, 5'd12, 32'h11,      1, 5'd13, 32'h22,       0, 5'd0,  5'd12, 32'h11,       0, 1, 0);
        vecs[22] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,         0, 5'd0,  5'd13, 32'h22,       0, 1, 0);

        rst_n = 1'b0;
        idle();
        raddr = '0;

        // Reset held: outputs zero, but a same-cycle write still shows through the bypass.
        @(negedge clk);
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h00000055; raddr[0] = 5'd3;
        #1;
        check("rst_bypass_rdata", rdata[0], 32'h55);
        check("rst_pending", pending, 0);
        check("rst_issue_ready", issue_ready, 0);
        check("rst_rbusy", rbusy, 0);
        @(negedge clk);
        idle();
        #1;
        check("rst_write_discarded", rdata[0], 0);
        #2 rst_n = 1'b1;

        // Vector table: inputs driven after the falling edge, outputs sampled 1 ns later.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            wb_valid = vecs[i].wb_v; wb_addr = vecs[i].wb_a; wb_data = vecs[i].wb_d;
            ld_valid = vecs[i].ld_v; ld_addr = vecs[i].ld_a; ld_data = vecs[i].ld_d;
            issue_valid = vecs[i].iss_v; issue_rd = vecs[i].iss_a;
            flush = 1'b0;
            raddr[0] = vecs[i].ra;
            #1;
            check($sformatf("v%0d_rdata", i), rdata[0], vecs[i].e_rdata);
            check($sformatf("v%0d_rbusy", i), rbusy[0], vecs[i].e_rbusy);
            check($sformatf("v%0d_ready", i), issue_ready, vecs[i].e_ready);
            check($sformatf("v%0d_pending", i), pending, vecs[i].e_pend);
        end

        // Reserve f1, f2, f4, then flush with a competing issue and a same-cycle write.
        @(negedge clk); idle(); issue_valid = 1'b1; issue_rd = 5'd1;
        @(negedge clk); issue_rd = 5'd2;
        @(negedge clk); issue_rd = 5'd4;
        @(negedge clk); idle();
        raddr[0] = 5'd1; raddr[1] = 5'd2; raddr[2] = 5'd4;
        #1;
        check("res3_pending", pending, 3);
        check("res3_rbusy", rbusy, 3'b111);
        @(negedge clk);
        flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd8;
        wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'h3F000000;
        #1;
        check("flush_blocks_issue", issue_ready, 0);
        check("flush_cycle_rbusy", rbusy, 3'b110);
        check("flush_cycle_pending", pending, 3);
        @(negedge clk); idle();
        raddr[0] = 5'd1; raddr[1] = 5'd2; raddr[2] = 5'd8;
        #1;
        check("post_flush_pending", pending, 0);
        check("post_flush_rbusy", rbusy, 3'b000);
        check("flush_write_kept", rdata[0], 32'h3F000000);

        // Reserve f6, then pulse reset mid-cycle.
        @(negedge clk); idle(); issue_valid = 1'b1; issue_rd = 5'd6;
        @(negedge clk); idle();
        raddr[0] = 5'd6; raddr[1] = 5'd3; raddr[2] = 5'd1;
        #1;
        check("f6_pending", pending, 1);
        check("f6_rbusy", rbusy[0], 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_pending", pending, 0);
        check("async_rst_rdata_f3", rdata[1], 0);
        check("async_rst_rdata_f1", rdata[2], 0);
        check("async_rst_rbusy", rbusy, 0);
        check("async_rst_ready", issue_ready, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        wb_valid = 1'b1; wb_addr = 5'd6; wb_data = 32'h40C00000;
        #1;
        check("post_rst_wb_rbusy", rbusy[0], 0);
        check("post_rst_wb_bypass", rdata[0], 32'h40C00000);
        @(negedge clk); idle();
        #1;
        check("post_rst_wb_pending", pending, 0);
        check("post_rst_wb_data", rdata[0], 32'h40C00000);
        check("post_rst_f3_cleared", rdata[1], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fp_regfile_sb

// File: doc/fp_regfile_sb.md
FP_REGFILE_SB -- requirements
Module: fp_regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32: register count, power of two; AW = log2(NUM_REGS).
REQ-003 SHALL have parameter NUM_RD, default 3: number of read ports.
REQ-004 SHALL have port clk_i  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port raddr_i  input  NUM_RD x AW: read addresses.
REQ-007 SHALL have port rdata_o  output  NUM_RD x DATA_W: read data.
REQ-008 SHALL have port rbusy_o  output  NUM_RD: the addressed register has a pending write.
REQ-009 SHALL have port issue_valid_i  input  1: request to reserve a destination register.
REQ-010 SHALL have port issue_rd_i  input  AW: destination register to reserve.
REQ-011 SHALL have port issue_ready_o  output  1: reservation is accepted this cycle.
REQ-012 SHALL have port wb_valid_i  input  1: FPU result write.
REQ-013 SHALL have ports wb_addr_i (input, AW) and wb_data_i (input, DATA_W): FPU result address and data.
REQ-014 SHALL have port ld_valid_i  input  1: load result write.
REQ-015 SHALL have ports ld_addr_i (input, AW) and ld_data_i (input, DATA_W): load result address and data.
REQ-016 SHALL have port flush_i  input  1: clears all reservations.
REQ-017 SHALL have port pending_o  output  AW+1: count of reserved registers.

Function
REQ-018 Writes SHALL take effect at the clock edge; rdata_o SHALL be combinational from the array with write-through bypass: a read of an address being written in the same cycle returns the incoming data.
REQ-019 If wb and ld target the same address in one cycle, wb SHALL win for both array and bypass data.
REQ-020 Each register SHALL hold a busy bit; rbusy_o[k] = busy[raddr_i[k]] AND NOT (a write to that address this cycle).
REQ-021 issue_ready_o SHALL be 1 iff the target is not busy, or is being written this cycle, and flush_i = 0.
REQ-022 A handshake (issue_valid_i AND issue_ready_o) SHALL set busy[issue_rd_i] at the next edge; set has priority over a same-cycle clear of the same register.
REQ-023 A wb or ld write SHALL clear busy for its address; writes to non-busy registers SHALL update data and leave busy at 0.
REQ-024 flush_i SHALL clear all busy bits at the next edge, blocking issue that cycle; same-cycle writes still update data.
REQ-025 pending_o SHALL equal the population count of busy bits, registered, updated at the same edge as those bits; it SHALL never exceed NUM_REGS.
REQ-026 Register 0 SHALL be an ordinary writable register (FP file, no hard-zero).

Reset
REQ-027 On rst_ni low, all registers, all busy bits and pending_o SHALL go to 0 immediately and asynchronously.
REQ-028 With rst_ni low, issue_ready_o, rbusy_o and rdata_o SHALL read 0, except that rdata_o shows bypass data for any same-cycle write.
REQ-029 Reset asserted with reservations outstanding SHALL discard them; later wb or ld writes SHALL behave as non-busy writes.

Structure
REQ-030 DATA_W and NUM_REGS defaults and the register-address typedef SHALL live in shared package fp_regfile_pkg.
REQ-031 Busy-bit tracking, issue_ready_o and pending_o SHALL be a sub-module fp_scoreboard; the data array and bypass SHALL stay in the top module.
REQ-032 The implementation SHALL contain no initial blocks; the reset path alone SHALL define the starting state.

Verification
REQ-033 Reset, then write wb f3 = 0x40400000; next cycle read f3 -> 0x40400000, rbusy 0.
REQ-034 Same cycle: wb f5 = 0x3F800000 and ld f5 = 0x40000000, raddr f5 -> rdata 0x3F800000 (bypass) that cycle, array holds 0x3F800000 after.
REQ-035 Issue f7 -> next cycle rbusy for f7 = 1, pending_o = 1; issue f7 again -> issue_ready_o = 0; wb f7 -> in that cycle issue_ready_o = 1 and rbusy for f7 = 0.
REQ-036 wb f9 and issue f9 in the same cycle -> f9 busy after the edge, pending_o = 1, data holds the wb value.
REQ-037 Reserve f1, f2, f4 -> pending_o = 3; flush_i -> next cycle pending_o = 0, all rbusy 0.
REQ-038 Reserve f6, pulse rst_ni low mid-cycle -> registers and pending_o read 0 immediately; then wb f6 -> pending_o stays 0.
